// File: rtl/squid_gf_pkg.sv
// GF(2^GF_M) field definitions and constant-multiply helpers shared by the
// SQUID RS decoder blocks, plus the Chien search FSM state encoding.
package squid_gf_pkg;

  localparam int GF_M = 4;
  localparam logic [GF_M:0] PRIM_POLY = 5'h13;

  typedef logic [GF_M-1:0] gf_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } chien_state_t;

  // Multiply by alpha (x) and reduce modulo the primitive polynomial.
  function automatic gf_t gf_xtime(gf_t a);
    gf_t r;
    r = {a[GF_M-2:0], 1'b0};
    if (a[GF_M-1]) r = r ^ PRIM_POLY[GF_M-1:0];
    return r;
  endfunction

  function automatic gf_t gf_alpha_pow(int e);
    gf_t r;
    int  n;
    r = gf_t'(1);
    n = e % ((1 << GF_M) - 1);
    for (int i = 0; i < n; i++) r = gf_xtime(r);
    return r;
  endfunction

  // With c a constant this collapses to a fixed XOR network.
  function automatic gf_t gf_cmul(gf_t a, gf_t c);
    gf_t acc;
    gf_t x;
    acc = '0;
    x   = a;
    for (int i = 0; i < GF_M; i++) begin
      if (c[i]) acc = acc ^ x;
      x = gf_xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/chien_search_seq_lane.sv
// One Chien search lane: evaluates sum_k r[k]*alpha^(k*(LANE+1)) and flags a zero.
module chien_lane
  import squid_gf_pkg::*;
#(
  parameter int T    = 2,
  parameter int LANE = 0
) (
  input  logic [T:0][GF_M-1:0] r,
  output logic                 is_root
);

  logic [T:0][GF_M-1:0] term;
  gf_t                  sum;

  for (genvar k = 0; k <= T; k++) begin : g_term
    localparam gf_t C = gf_alpha_pow(k * (LANE + 1));
    assign term[k] = gf_cmul(r[k], C);
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k <= T; k++) sum = sum ^ term[k];
    is_root = (sum == '0);
  end

endmodule

// File: rtl/chien_search_seq.sv
// Sequential Chien search: P positions per cycle, locator bitmap, root count
// and an uncorrectable flag when the root count disagrees with deg(Lambda).
module chien_search_seq
  import squid_gf_pkg::*;
#(
  parameter int T          = 2,
  parameter int N_POS      = 8,
  parameter int P          = 2,
  parameter int EARLY_STOP = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [T:0][GF_M-1:0]       lambda,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_POS-1:0]           locator,
  output logic [$clog2(N_POS+1)-1:0] root_cnt,
  output logic                       uncorrectable
);

  localparam int NCYC = (N_POS + P - 1) / P;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int RW   = $clog2(N_POS + 1);
  localparam int DW   = $clog2(T + 2);

  chien_state_t         state, state_nx;
  logic [CW-1:0]        cyc;
  logic [T:0][GF_M-1:0] r_reg, r_step;
  logic [DW-1:0]        deg, deg_in;
  logic [P-1:0]         hit;
  logic [N_POS-1:0]     loc_nx;
  logic [RW-1:0]        cnt_nx;
  logic                 last_cyc, stop;

  for (genvar p = 0; p < P; p++) begin : g_lane
    chien_lane #(.T(T), .LANE(p)) u_lane (.r(r_reg), .is_root(hit[p]));
  end

  // Advance each coefficient by alpha^(k*P) so lane p sees the next block of positions.
  for (genvar k = 0; k <= T; k++) begin : g_step
    localparam gf_t STEP = gf_alpha_pow(k * P);
    assign r_step[k] = gf_cmul(r_reg[k], STEP);
  end

  always_comb begin
    deg_in = '0;
    for (int k = 0; k <= T; k++)
      if (lambda[k] != '0) deg_in = DW'(k);
  end

  // Lanes whose position falls past N_POS never match any locator bit.
  always_comb begin
    loc_nx = locator;
    cnt_nx = root_cnt;
    for (int p = 0; p < P; p++)
      for (int i = 0; i < N_POS; i++)
        if (int'(cyc) * P + p == i) begin
          loc_nx[i] = hit[p];
          if (hit[p]) cnt_nx = cnt_nx + RW'(1);
        end
    last_cyc = (cyc == CW'(NCYC - 1));
    stop = last_cyc ||
           ((EARLY_STOP != 0) && (deg != '0) && (int'(cnt_nx) == int'(deg)));
  end

  always_comb begin
    state_nx  = state;
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    unique case (state)
      S_IDLE:   if (in_valid) state_nx = (lambda[0] == '0) ? S_DONE : S_SEARCH;
      S_SEARCH: if (stop) state_nx = S_DONE;
      S_DONE:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cyc           <= '0;
      r_reg         <= '0;
      deg           <= '0;
      locator       <= '0;
      root_cnt      <= '0;
      uncorrectable <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: if (in_valid) begin
          r_reg    <= lambda;
          deg      <= deg_in;
          locator  <= '0;
          root_cnt <= '0;
          cyc      <= '0;
          if (lambda[0] == '0) uncorrectable <= 1'b1;
        end
        S_SEARCH: begin
          r_reg    <= r_step;
          locator  <= loc_nx;
          root_cnt <= cnt_nx;
          cyc      <= cyc + CW'(1);
          if (stop) uncorrectable <= (int'(cnt_nx) != int'(deg));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chien_search_seq.sv
// Directed bench for chien_search_seq: early-stop P=2, full-run P=2 and
// full-run P=3 (masked last lane) instances share one stimulus stream.
module tb_chien_search_seq;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic [2:0][3:0] lambda;

  logic       in_ready_d, out_valid_d, unc_d;
  logic       in_ready_f, out_valid_f, unc_f;
  logic       in_ready_3, out_valid_3, unc_3;
  logic [7:0] locator_d, locator_f, locator_3;
  logic [3:0] root_cnt_d, root_cnt_f, root_cnt_3;
  logic [12:0] res_d, res_f, res_3;

  int errors = 0;
  int checks = 0;
  int lat_d, lat_f, lat_3;

  assign res_d = {locator_d, root_cnt_d, unc_d};
  assign res_f = {locator_f, root_cnt_f, unc_f};
  assign res_3 = {locator_3, root_cnt_3, unc_3};

  always #5 clk = ~clk;

  chien_search_seq #(.EARLY_STOP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
    .lambda(lambda), .out_valid(out_valid_d), .out_ready(out_ready),
    .locator(locator_d), .root_cnt(root_cnt_d), .uncorrectable(unc_d));

  chien_search_seq #(.EARLY_STOP(0)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .lambda(lambda), .out_valid(out_valid_f), .out_ready(out_ready),
    .locator(locator_f), .root_cnt(root_cnt_f), .uncorrectable(unc_f));

  chien_search_seq #(.P(3), .EARLY_STOP(0)) u_p3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_3),
    .lambda(lambda), .out_valid(out_valid_3), .out_ready(out_ready),
    .locator(locator_3), .root_cnt(root_cnt_3), .uncorrectable(unc_3));

  // Offers one lambda and records, per instance, how many edges after the
  // accepting edge out_valid was first seen (-1 if never within the budget).
  task automatic run_lambda(input logic [11:0] lam);
    @(negedge clk);
    lambda    = lam;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat_d = -1; lat_f = -1; lat_3 = -1;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (lat_d < 0 && out_valid_d) lat_d = n;
      if (lat_f < 0 && out_valid_f) lat_f = n;
      if (lat_3 < 0 && out_valid_3) lat_3 = n;
      if (lat_d >= 0 && lat_f >= 0 && lat_3 >= 0) break;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready_d !== 1'b1 || out_valid_d !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got in_ready=%b out_valid=%b, expected 1/0", in_ready_d, out_valid_d);
    end
    checks++;
    if (res_d !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0000", res_d);
    end
    checks++;
    if ({in_ready_f, out_valid_f, in_ready_3, out_valid_3} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL reset_other_instances: got %b, expected 1010", {in_ready_f, out_valid_f, in_ready_3, out_valid_3});
    end
  endtask

  task automatic test_two_roots(input string tag);
    run_lambda(12'h168);
    checks++;
    if ({lat_d, lat_f, lat_3} !== {32'sd1, 32'sd4, 32'sd3}) begin
      errors++;
      $display("[TB] FAIL %s_latency: got es=%0d full=%0d p3=%0d, expected 1/4/3", tag, lat_d, lat_f, lat_3);
    end
    checks++;
    if (res_d !== {8'h03, 4'd2, 1'b0} || res_f !== {8'h03, 4'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s_result: got es=%h full=%h, expected 0064", tag, res_d, res_f);
    end
    checks++;
    if (res_3 !== {8'h03, 4'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s_result_p3: got %h, expected 0064", tag, res_3);
    end
  endtask

  task automatic test_single_root();
    run_lambda(12'h018);
    checks++;
    if ({lat_d, lat_f, lat_3} !== {32'sd2, 32'sd4, 32'sd3}) begin
      errors++;
      $display("[TB] FAIL single_root_latency: got es=%0d full=%0d p3=%0d, expected 2/4/3", lat_d, lat_f, lat_3);
    end
    checks++;
    if (res_d !== {8'h04, 4'd1, 1'b0} || res_f !== {8'h04, 4'd1, 1'b0} || res_3 !== {8'h04, 4'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_root_result: got es=%h full=%h p3=%h, expected 0082", res_d, res_f, res_3);
    end
    release_result();
  endtask

  task automatic test_degenerate();
    run_lambda(12'h001);
    checks++;
    if ({lat_d, lat_f, lat_3} !== {32'sd4, 32'sd4, 32'sd3}) begin
      errors++;
      $display("[TB] FAIL no_error_latency: got es=%0d full=%0d p3=%0d, expected 4/4/3", lat_d, lat_f, lat_3);
    end
    checks++;
    if (res_d !== 13'h0 || res_f !== 13'h0 || res_3 !== 13'h0) begin
      errors++;
      $display("[TB] FAIL no_error_result: got es=%h full=%h p3=%h, expected 0000", res_d, res_f, res_3);
    end
    release_result();
    run_lambda(12'h100);
    checks++;
    if ({lat_d, lat_f, lat_3} !== {32'sd0, 32'sd0, 32'sd0}) begin
      errors++;
      $display("[TB] FAIL zero_const_latency: got es=%0d full=%0d p3=%0d, expected 0/0/0", lat_d, lat_f, lat_3);
    end
    checks++;
    if (res_d !== 13'h1 || res_f !== 13'h1 || res_3 !== 13'h1) begin
      errors++;
      $display("[TB] FAIL zero_const_result: got es=%h full=%h p3=%h, expected 0001", res_d, res_f, res_3);
    end
    release_result();
  endtask

  task automatic test_outside_range();
    run_lambda(12'h1D3);
    checks++;
    if ({lat_d, lat_f, lat_3} !== {32'sd4, 32'sd4, 32'sd3}) begin
      errors++;
      $display("[TB] FAIL outside_latency: got es=%0d full=%0d p3=%0d, expected 4/4/3", lat_d, lat_f, lat_3);
    end
    checks++;
    if (res_d !== 13'h1 || res_f !== 13'h1) begin
      errors++;
      $display("[TB] FAIL outside_result: got es=%h full=%h, expected 0001", res_d, res_f);
    end
    checks++;
    if (res_3 !== 13'h1) begin
      errors++;
      $display("[TB] FAIL masked_lane_p3: got %h, expected 0001", res_3);
    end
    release_result();
  endtask

  // Result from the preceding two-root run must sit still while out_ready is low.
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lambda    = 12'h018;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (res_d !== {8'h03, 4'd2, 1'b0} || out_valid_d !== 1'b1 || in_ready_d !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stable[%0d]: got res=%h ov=%b ir=%b, expected 0064/1/0", i, res_d, out_valid_d, in_ready_d);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready_d !== 1'b1 || out_valid_d !== 1'b0 || res_d !== {8'h03, 4'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL release_to_idle: got ir=%b ov=%b res=%h, expected 1/0/0064", in_ready_d, out_valid_d, res_d);
    end
    test_single_root();
  endtask

  task automatic test_reset_mid_search();
    @(negedge clk);
    lambda   = 12'h1D3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid_d, in_ready_d, out_valid_f, in_ready_f, out_valid_3, in_ready_3} !== 6'b010101) begin
      errors++;
      $display("[TB] FAIL abort_handshake: got %b, expected 010101", {out_valid_d, in_ready_d, out_valid_f, in_ready_f, out_valid_3, in_ready_3});
    end
    checks++;
    if (res_d !== 13'h0 || res_f !== 13'h0 || res_3 !== 13'h0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got es=%h full=%h p3=%h, expected 0000", res_d, res_f, res_3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_two_roots("after_abort");
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lambda    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_two_roots("two_roots");
    test_back_to_back();
    test_degenerate();
    test_outside_range();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
